emmc_init_seq: RTL and testbench
================================

EMMC_INIT_SEQ -- requirements
Module: emmc_init_seq

Interface
Parameters (name, default, meaning):
REQ-001 SHALL provide parameters:
- CMD1_RETRY_MAX, 1000: maximum CMD1 attempts.
- RCA, 16'h0001: relative card address assigned by CMD3.
- OCR_ARG, 32'h40FF8080: CMD1 argument.
- CMD0_WAIT, 64: mclk cycles waited after CMD0, which has no response.
- GAP_CYCLES, 8: idle mclk cycles between response end and the next send_cmd.

Ports (name, direction, width, meaning):
REQ-002 SHALL have the ports below.
- mclk, input, 1: clock; all logic on the rising edge.
- rstn, input, 1: reset; asynchronous, active-low.
- start, input, 1: one-cycle request to run the init sequence.
- send_cmd, output, 1: one-cycle pulse to eMMC_Socket.
- cmd_index, output, 6: command index to eMMC_Socket.
- cmd_argument, output, 32: command argument to eMMC_Socket.
- resp_valid, input, 1: one-cycle pulse; socket received a response.
- resp_timeout, input, 1: one-cycle pulse; no response within the socket timeout.
- resp_arg, input, 32: response bits [39:8]; valid with resp_valid.
- busy, output, 1: sequence in progress.
- init_done, output, 1: sequence finished successfully; sticky.
- init_fail, output, 1: sequence aborted; sticky.
- fail_code, output, 3: failing step, 1=CMD1 retries exhausted, 2=CMD1, 3=CMD2, 4=CMD3, 5=CMD7 (codes 2-5 = timeout on that command).
- rca_o, output, 16: RCA in use; valid when init_done=1.

Function
REQ-003 States SHALL be: IDLE, C0_SEND, C0_WAIT, C1_SEND, C1_WAIT, C1_GAP, C2_SEND, C2_WAIT, C3_SEND, C3_WAIT, C7_SEND, C7_WAIT, GAP, DONE, FAIL.
REQ-004 In IDLE, DONE or FAIL, start=1 SHALL go to C0_SEND next cycle, clear init_done, init_fail and fail_code, and zero the retry counter.
REQ-005 start while busy=1 SHALL be ignored.
REQ-006 Each *_SEND state SHALL last exactly one cycle, assert send_cmd=1, and present cmd_index/cmd_argument in that same cycle.
REQ-007 cmd_index/cmd_argument SHALL hold their last values until the next *_SEND state.
REQ-008 Command values SHALL be:
- CMD0: index 0, argument 0.
- CMD1: index 1, argument OCR_ARG.
- CMD2: index 2, argument 0.
- CMD3: index 3, argument {RCA,16'h0000}.
- CMD7: index 7, argument {RCA,16'h0000}.
REQ-009 C0_WAIT SHALL count CMD0_WAIT cycles, then enter C1_SEND; resp_valid and resp_timeout SHALL be ignored in C0_WAIT.
REQ-010 In C1_WAIT, resp_valid with resp_arg[31]=1 SHALL go to GAP, then C2_SEND.
REQ-011 In C1_WAIT, resp_valid with resp_arg[31]=0 SHALL increment the retry counter.
- If the new count equals CMD1_RETRY_MAX: go to FAIL with fail_code=1.
- Otherwise: go to C1_GAP, then C1_SEND.
REQ-012 In C2_WAIT, C3_WAIT or C7_WAIT, resp_valid SHALL advance via GAP to the next command; the response content SHALL be ignored.
- After C7_WAIT the next state is DONE.
REQ-013 resp_timeout in any *_WAIT except C0_WAIT SHALL go to FAIL with the matching fail_code 2-5.
REQ-014 If resp_valid and resp_timeout are asserted in the same cycle, resp_timeout SHALL take priority.
REQ-015 resp_valid or resp_timeout outside a *_WAIT state SHALL be ignored.
REQ-016 GAP and C1_GAP SHALL each hold for exactly GAP_CYCLES cycles with send_cmd=0.
REQ-017 Total spacing SHALL be GAP_CYCLES+1 cycles from the resp_valid edge to the next send_cmd.
REQ-018 busy SHALL be 1 in every state except IDLE, DONE and FAIL.
REQ-019 On entering DONE, init_done SHALL be 1 and rca_o SHALL equal RCA; on entering FAIL, init_fail SHALL be 1.
REQ-020 init_done and init_fail SHALL never both be 1.
REQ-021 The retry counter SHALL be wide enough for CMD1_RETRY_MAX and SHALL NOT wrap.
REQ-022 Timeout detection is owned by eMMC_Socket; this block SHALL have no internal watchdog.

Reset
REQ-023 rstn=0 SHALL immediately force:
- State: IDLE.
- Outputs: send_cmd=0, cmd_index=0, cmd_argument=0, busy=0, init_done=0, init_fail=0, fail_code=0, rca_o=0.
- Counters: all zero.
REQ-024 Reset mid-sequence SHALL abort without emitting any further send_cmd.
REQ-025 After reset release, the block SHALL stay in IDLE until start.

Verification
REQ-026 Happy path: start; CMD1 response 32'h80FF8080 on the first try; CMD2/3/7 responses -> send_cmd pulses with indices 0,1,2,3,7; CMD3 and CMD7 arguments 32'h00010000; init_done=1; rca_o=16'h0001; busy=0.
REQ-027 CMD1 polling: two responses 32'h00FF8080, then 32'h80FF8080 -> exactly three CMD1 sends, each send GAP_CYCLES+1 cycles after the prior response; then CMD2.
REQ-028 Retry exhaustion with CMD1_RETRY_MAX=3: every CMD1 response 32'h00FF8080 -> three CMD1 sends; init_fail=1; fail_code=1; no CMD2.
REQ-029 Timeout: resp_timeout during C3_WAIT -> init_fail=1, fail_code=4, no CMD7; then start -> flags cleared and CMD0 resent.
REQ-030 Simultaneous resp_valid and resp_timeout in C2_WAIT -> fail_code=3.
REQ-031 Reset and stray pulses:
- Reset asserted in C1_GAP -> all outputs at reset values in the same cycle; no send_cmd afterward.
- Stray resp_valid in IDLE -> no state change.

Source files
------------

// File: rtl/emmc_init_seq.sv
// eMMC card initialisation sequencer: CMD0 -> CMD1 (OCR poll) -> CMD2 -> CMD3 -> CMD7.
// Drives command requests to the socket and consumes its response/timeout pulses.
module emmc_init_seq #(
    parameter int          CMD1_RETRY_MAX = 1000,
    parameter logic [15:0] RCA            = 16'h0001,
    parameter logic [31:0] OCR_ARG        = 32'h40FF8080,
    parameter int          CMD0_WAIT      = 64,
    parameter int          GAP_CYCLES     = 8
) (
    input  logic        mclk,
    input  logic        rstn,
    input  logic        start,
    output logic        send_cmd,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_argument,
    input  logic        resp_valid,
    input  logic        resp_timeout,
    input  logic [31:0] resp_arg,
    output logic        busy,
    output logic        init_done,
    output logic        init_fail,
    output logic [2:0]  fail_code,
    output logic [15:0] rca_o
);

    localparam int CNT_MAX = (CMD0_WAIT > GAP_CYCLES) ? CMD0_WAIT : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = $clog2(CMD1_RETRY_MAX + 1);
    localparam logic [CW-1:0] C0_LOAD    = CW'(CMD0_WAIT - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(CMD1_RETRY_MAX - 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_C0_SEND = 4'd1,
        S_C0_WAIT = 4'd2,
        S_C1_SEND = 4'd3,
        S_C1_WAIT = 4'd4,
        S_C1_GAP  = 4'd5,
        S_C2_SEND = 4'd6,
        S_C2_WAIT = 4'd7,
        S_C3_SEND = 4'd8,
        S_C3_WAIT = 4'd9,
        S_C7_SEND = 4'd10,
        S_C7_WAIT = 4'd11,
        S_GAP     = 4'd12,
        S_DONE    = 4'd13,
        S_FAIL    = 4'd14
    } state_t;

    state_t          r_state;
    state_t          r_gap_next;
    logic [CW-1:0]   r_cnt;
    logic [RW-1:0]   r_retry;
    logic            r_send_cmd;
    logic [5:0]      r_cmd_index;
    logic [31:0]     r_cmd_arg;
    logic            r_busy;
    logic            r_init_done;
    logic            r_init_fail;
    logic [2:0]      r_fail_code;
    logic [15:0]     r_rca;
    logic            w_unused_arg;

    // Only the OCR busy bit of the response is of interest here
    assign w_unused_arg = ^resp_arg[30:0];

    function automatic logic [5:0] f_cmd_index(input state_t s);
        case (s)
            S_C0_SEND: f_cmd_index = 6'd0;
            S_C1_SEND: f_cmd_index = 6'd1;
            S_C2_SEND: f_cmd_index = 6'd2;
            S_C3_SEND: f_cmd_index = 6'd3;
            S_C7_SEND: f_cmd_index = 6'd7;
            default:   f_cmd_index = 6'd0;
        endcase
    endfunction

    function automatic logic [31:0] f_cmd_arg(input state_t s);
        case (s)
            S_C1_SEND: f_cmd_arg = OCR_ARG;
            S_C3_SEND: f_cmd_arg = {RCA, 16'h0000};
            S_C7_SEND: f_cmd_arg = {RCA, 16'h0000};
            default:   f_cmd_arg = 32'h0000_0000;
        endcase
    endfunction

    // Sequencer FSM; every output is loaded on the edge that enters the state it belongs to
    always_ff @(posedge mclk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_gap_next  <= S_IDLE;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_send_cmd  <= 1'b0;
            r_cmd_index <= 6'd0;
            r_cmd_arg   <= 32'h0000_0000;
            r_busy      <= 1'b0;
            r_init_done <= 1'b0;
            r_init_fail <= 1'b0;
            r_fail_code <= 3'd0;
            r_rca       <= 16'h0000;
        end else begin
            r_send_cmd <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        r_state     <= S_C0_SEND;
                        r_send_cmd  <= 1'b1;
                        r_cmd_index <= f_cmd_index(S_C0_SEND);
                        r_cmd_arg   <= f_cmd_arg(S_C0_SEND);
                        r_busy      <= 1'b1;
                        r_init_done <= 1'b0;
                        r_init_fail <= 1'b0;
                        r_fail_code <= 3'd0;
                        r_retry     <= '0;
                        r_rca       <= 16'h0000;
                    end
                end
                S_C0_SEND: begin
                    r_state <= S_C0_WAIT;
                    r_cnt   <= C0_LOAD;
                end
                S_C0_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state     <= S_C1_SEND;
                        r_send_cmd  <= 1'b1;
                        r_cmd_index <= f_cmd_index(S_C1_SEND);
                        r_cmd_arg   <= f_cmd_arg(S_C1_SEND);
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_C1_SEND: r_state <= S_C1_WAIT;
                S_C1_WAIT: begin
                    if (resp_timeout) begin
                        r_state     <= S_FAIL;
                        r_busy      <= 1'b0;
                        r_init_fail <= 1'b1;
                        r_fail_code <= 3'd2;
                    end else if (resp_valid) begin
                        if (resp_arg[31]) begin
                            r_state    <= S_GAP;
                            r_gap_next <= S_C2_SEND;
                            r_cnt      <= GAP_LOAD;
                        end else if (r_retry == RETRY_LAST) begin
                            // Counter stops at the limit, so it can never wrap
                            r_retry     <= r_retry + RW'(1);
                            r_state     <= S_FAIL;
                            r_busy      <= 1'b0;
                            r_init_fail <= 1'b1;
                            r_fail_code <= 3'd1;
                        end else begin
                            r_retry <= r_retry + RW'(1);
                            r_state <= S_C1_GAP;
                            r_cnt   <= GAP_LOAD;
                        end
                    end
                end
                S_C1_GAP: begin
                    if (r_cnt == '0) begin
                        r_state     <= S_C1_SEND;
                        r_send_cmd  <= 1'b1;
                        r_cmd_index <= f_cmd_index(S_C1_SEND);
                        r_cmd_arg   <= f_cmd_arg(S_C1_SEND);
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_C2_SEND: r_state <= S_C2_WAIT;
                S_C2_WAIT: begin
                    if (resp_timeout) begin
                        r_state     <= S_FAIL;
                        r_busy      <= 1'b0;
                        r_init_fail <= 1'b1;
                        r_fail_code <= 3'd3;
                    end else if (resp_valid) begin
                        r_state    <= S_GAP;
                        r_gap_next <= S_C3_SEND;
                        r_cnt      <= GAP_LOAD;
                    end
                end
                S_C3_SEND: r_state <= S_C3_WAIT;
                S_C3_WAIT: begin
                    if (resp_timeout) begin
                        r_state     <= S_FAIL;
                        r_busy      <= 1'b0;
                        r_init_fail <= 1'b1;
                        r_fail_code <= 3'd4;
                    end else if (resp_valid) begin
                        r_state    <= S_GAP;
                        r_gap_next <= S_C7_SEND;
                        r_cnt      <= GAP_LOAD;
                    end
                end
                S_C7_SEND: r_state <= S_C7_WAIT;
                S_C7_WAIT: begin
                    if (resp_timeout) begin
                        r_state     <= S_FAIL;
                        r_busy      <= 1'b0;
                        r_init_fail <= 1'b1;
                        r_fail_code <= 3'd5;
                    end else if (resp_valid) begin
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_init_done <= 1'b1;
                        r_rca       <= RCA;
                    end
                end
                S_GAP: begin
                    if (r_cnt == '0) begin
                        r_state     <= r_gap_next;
                        r_send_cmd  <= 1'b1;
                        r_cmd_index <= f_cmd_index(r_gap_next);
                        r_cmd_arg   <= f_cmd_arg(r_gap_next);
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign send_cmd     = r_send_cmd;
    assign cmd_index    = r_cmd_index;
    assign cmd_argument = r_cmd_arg;
    assign busy         = r_busy;
    assign init_done    = r_init_done;
    assign init_fail    = r_init_fail;
    assign fail_code    = r_fail_code;
    assign rca_o        = r_rca;

endmodule

// File: tb/tb_emmc_init_seq.sv
// Directed bench for emmc_init_seq: a scripted socket answers each command
// and command spacing, flags and codes are checked against hand-computed values.
module tb_emmc_init_seq;

    localparam int          G    = 5;
    localparam int          C0W  = 12;
    localparam int          RMAX = 3;
    localparam logic [31:0] OCR  = 32'h40FF8080;
    localparam logic [31:0] RARG = 32'h00010000;

    logic        mclk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        resp_valid = 1'b0;
    logic        resp_timeout = 1'b0;
    logic [31:0] resp_arg = 32'h0;
    logic        send_cmd;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_argument;
    logic        busy;
    logic        init_done;
    logic        init_fail;
    logic [2:0]  fail_code;
    logic [15:0] rca_o;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_sends = 0;

    emmc_init_seq #(
        .CMD1_RETRY_MAX(RMAX),
        .RCA(16'h0001),
        .OCR_ARG(OCR),
        .CMD0_WAIT(C0W),
        .GAP_CYCLES(G)
    ) dut (
        .mclk(mclk), .rstn(rstn), .start(start),
        .send_cmd(send_cmd), .cmd_index(cmd_index), .cmd_argument(cmd_argument),
        .resp_valid(resp_valid), .resp_timeout(resp_timeout), .resp_arg(resp_arg),
        .busy(busy), .init_done(init_done), .init_fail(init_fail),
        .fail_code(fail_code), .rca_o(rca_o)
    );

    always #5 mclk = ~mclk;

    always @(posedge mclk) cyc <= cyc + 1;

    always @(negedge mclk) if (send_cmd === 1'b1) n_sends <= n_sends + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge mclk); start = 1'b1;
        @(negedge mclk); start = 1'b0;
    endtask

    // Waits (bounded) for a send_cmd pulse, checks it, returns its cycle number
    task automatic wait_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg, output int c);
        int n = 0;
        while (send_cmd !== 1'b1 && n < 300) begin
            @(negedge mclk);
            n++;
        end
        check_val({tag, "_seen"}, {31'd0, send_cmd}, 32'd1);
        check_val({tag, "_idx"}, {26'd0, cmd_index}, {26'd0, idx});
        check_val({tag, "_arg"}, cmd_argument, arg);
        c = cyc;
        @(negedge mclk);
    endtask

    task automatic pulse_resp(input logic v, input logic t, input logic [31:0] a, output int rc);
        @(negedge mclk);
        resp_valid = v; resp_timeout = t; resp_arg = a;
        rc = cyc;
        @(negedge mclk);
        resp_valid = 1'b0; resp_timeout = 1'b0; resp_arg = 32'h0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(negedge mclk);
            n++;
        end
        check_val("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int c0, c1, c2, rc, ns;

        // Reset values
        repeat (3) @(negedge mclk);
        check_val("rst_send", {31'd0, send_cmd}, 32'd0);
        check_val("rst_idx", {26'd0, cmd_index}, 32'd0);
        check_val("rst_arg", cmd_argument, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, init_done}, 32'd0);
        check_val("rst_fail", {31'd0, init_fail}, 32'd0);
        check_val("rst_code", {29'd0, fail_code}, 32'd0);
        check_val("rst_rca", {16'd0, rca_o}, 32'd0);
        rstn = 1'b1;
        repeat (3) @(negedge mclk);

        // Stray response in IDLE
        pulse_resp(1'b1, 1'b0, 32'h80FF8080, rc);
        repeat (5) @(negedge mclk);
        check_val("stray_busy", {31'd0, busy}, 32'd0);
        check_val("stray_sends", n_sends, 32'd0);

        // Happy path, including an ignored start while busy
        pulse_start();
        wait_cmd("h_c0", 6'd0, 32'd0, c0);
        check_val("h_busy", {31'd0, busy}, 32'd1);
        repeat (2) @(negedge mclk);
        start = 1'b1;
        @(negedge mclk);
        start = 1'b0;
        wait_cmd("h_c1", 6'd1, OCR, c1);
        check_val("h_c0_space", c1 - c0, 32'd13);
        pulse_resp(1'b1, 1'b0, 32'h80FF8080, rc);
        wait_cmd("h_c2", 6'd2, 32'd0, c2);
        check_val("h_c1_space", c2 - rc, 32'd6);
        pulse_resp(1'b1, 1'b0, 32'h12345678, rc);
        wait_cmd("h_c3", 6'd3, RARG, c2);
        check_val("h_c2_space", c2 - rc, 32'd6);
        pulse_resp(1'b1, 1'b0, 32'hABCD0000, rc);
        wait_cmd("h_c7", 6'd7, RARG, c2);
        check_val("h_c3_space", c2 - rc, 32'd6);
        pulse_resp(1'b1, 1'b0, 32'h00000700, rc);
        wait_idle();
        check_val("h_done", {31'd0, init_done}, 32'd1);
        check_val("h_fail", {31'd0, init_fail}, 32'd0);
        check_val("h_rca", {16'd0, rca_o}, 32'h0001);
        check_val("h_code", {29'd0, fail_code}, 32'd0);
        check_val("h_idx_hold", {26'd0, cmd_index}, 32'd7);
        check_val("h_arg_hold", cmd_argument, RARG);
        check_val("h_sends", n_sends, 32'd5);

        // CMD1 polling: two not-ready responses, then ready
        pulse_start();
        check_val("p_done_clr", {31'd0, init_done}, 32'd0);
        check_val("p_rca_clr", {16'd0, rca_o}, 32'd0);
        wait_cmd("p_c0", 6'd0, 32'd0, c0);
        wait_cmd("p_c1a", 6'd1, OCR, c1);
        pulse_resp(1'b1, 1'b0, 32'h00FF8080, rc);
        wait_cmd("p_c1b", 6'd1, OCR, c1);
        check_val("p_c1b_space", c1 - rc, 32'd6);
        pulse_resp(1'b1, 1'b0, 32'h00FF8080, rc);
        wait_cmd("p_c1c", 6'd1, OCR, c1);
        check_val("p_c1c_space", c1 - rc, 32'd6);
        pulse_resp(1'b1, 1'b0, 32'h80FF8080, rc);
        wait_cmd("p_c2", 6'd2, 32'd0, c2);
        check_val("p_c2_space", c2 - rc, 32'd6);

        // Simultaneous valid and timeout in C2_WAIT: timeout wins
        pulse_resp(1'b1, 1'b1, 32'h0, rc);
        wait_idle();
        check_val("s_fail", {31'd0, init_fail}, 32'd1);
        check_val("s_code", {29'd0, fail_code}, 32'd3);
        check_val("s_done", {31'd0, init_done}, 32'd0);

        // Retry exhaustion with CMD1_RETRY_MAX=3
        ns = n_sends;
        pulse_start();
        check_val("x_fail_clr", {31'd0, init_fail}, 32'd0);
        check_val("x_code_clr", {29'd0, fail_code}, 32'd0);
        wait_cmd("x_c0", 6'd0, 32'd0, c0);
        for (int i = 0; i < 3; i++) begin
            wait_cmd("x_c1", 6'd1, OCR, c1);
            pulse_resp(1'b1, 1'b0, 32'h00FF8080, rc);
        end
        repeat (20) @(negedge mclk);
        check_val("x_fail", {31'd0, init_fail}, 32'd1);
        check_val("x_code", {29'd0, fail_code}, 32'd1);
        check_val("x_busy", {31'd0, busy}, 32'd0);
        check_val("x_sends", n_sends - ns, 32'd4);

        // Timeout in C3_WAIT, then restart
        pulse_start();
        wait_cmd("t_c0", 6'd0, 32'd0, c0);
        wait_cmd("t_c1", 6'd1, OCR, c1);
        pulse_resp(1'b1, 1'b0, 32'h80FF8080, rc);
        wait_cmd("t_c2", 6'd2, 32'd0, c2);
        pulse_resp(1'b1, 1'b0, 32'h0, rc);
        wait_cmd("t_c3", 6'd3, RARG, c2);
        ns = n_sends;
        pulse_resp(1'b0, 1'b1, 32'h0, rc);
        repeat (20) @(negedge mclk);
        check_val("t_fail", {31'd0, init_fail}, 32'd1);
        check_val("t_code", {29'd0, fail_code}, 32'd4);
        check_val("t_no_c7", n_sends - ns, 32'd0);
        pulse_start();
        check_val("r_fail_clr", {31'd0, init_fail}, 32'd0);
        check_val("r_code_clr", {29'd0, fail_code}, 32'd0);
        check_val("r_busy", {31'd0, busy}, 32'd1);
        wait_cmd("r_c0", 6'd0, 32'd0, c0);

        // Reset asserted in C1_GAP
        wait_cmd("r_c1", 6'd1, OCR, c1);
        pulse_resp(1'b1, 1'b0, 32'h00FF8080, rc);
        @(negedge mclk);
        rstn = 1'b0;
        #1;
        check_val("ra_idx", {26'd0, cmd_index}, 32'd0);
        check_val("ra_arg", cmd_argument, 32'd0);
        check_val("ra_busy", {31'd0, busy}, 32'd0);
        check_val("ra_send", {31'd0, send_cmd}, 32'd0);
        check_val("ra_flags", {30'd0, init_done, init_fail}, 32'd0);
        ns = n_sends;
        @(negedge mclk);
        rstn = 1'b1;
        repeat (30) @(negedge mclk);
        check_val("ra_no_send", n_sends - ns, 32'd0);
        check_val("ra_idle", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
